l2_mem_responder: RTL
=====================

Name: l2_mem_responder

Overview:
- Memory-side responder for the L1 data cache miss interface: accepts line-wide read/write requests from the cache's memory request port and returns read data with the original tag.
- Backs requests with an internal line-organised SRAM, fixed read latency and a credit-guarded response queue.
- Serves as the L2/backing-store endpoint in compute-unit simulation and as a synthesizable stand-in for the L2 data cache.

Parameters:
- LINE_SIZE, 64, bytes per cache line; data width is LINE_SIZE*8.
- ADDR_WIDTH, 26, line-address width of mem_req_addr_i.
- TAG_WIDTH, 8, width of the request/response tag.
- MEM_LINES, 1024, SRAM depth in lines; power of two.
- LATENCY, 4, cycles from read acceptance to earliest rsp_valid; must be >= 1.
- RSQ_DEPTH, 4, maximum outstanding reads; response FIFO depth.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mem_req_valid_i  in  1  request valid
- mem_req_rw_i  in  1  1=write, 0=read
- mem_req_byteen_i  in  LINE_SIZE  write byte enables
- mem_req_addr_i  in  ADDR_WIDTH  line address
- mem_req_data_i  in  LINE_SIZE*8  write data
- mem_req_tag_i  in  TAG_WIDTH  request tag
- mem_req_ready_o  out  1  request accepted when valid&ready
- mem_rsp_valid_o  out  1  read response valid
- mem_rsp_data_o  out  LINE_SIZE*8  read line data
- mem_rsp_tag_o  out  TAG_WIDTH  tag of the originating read
- mem_rsp_ready_i  in  1  consumer accepts response

Behaviour:
- Reset:
  - mem_req_ready_o=0 while rst_i=1.
  - mem_rsp_valid_o=0; mem_rsp_data_o and mem_rsp_tag_o are 0.
  - Pipeline valids, FIFO pointers and the outstanding counter clear to 0.
  - SRAM contents are not reset and are retained across reset.
- Indexing: SRAM index = mem_req_addr_i[log2(MEM_LINES)-1:0]. Upper address bits are ignored, so addresses alias modulo MEM_LINES.
- Ready:
  - mem_req_ready_o = ~rst_i & (outstanding < RSQ_DEPTH).
  - Ready is independent of mem_req_valid_i and mem_req_rw_i; there is no combinational path from valid to ready.
- Write accept (valid&ready&rw):
  - SRAM bytes with byteen=1 are updated at the accepting edge; byteen=0 bytes are unchanged.
  - No response is generated and no credit is consumed.
- Read accept (valid&ready&~rw):
  - SRAM read occurs in the accept cycle t.
  - Data and tag travel through LATENCY-1 register stages, then enter the response FIFO.
  - mem_rsp_valid_o rises at cycle t+LATENCY earliest.
  - outstanding increments by 1.
- Ordering:
  - One request per cycle; responses return strictly in acceptance order.
  - A write accepted at cycle t is visible to a read accepted at t+1 or later.
- Response handshake:
  - mem_rsp_valid_o = FIFO non-empty.
  - data and tag come from the FIFO head and stay stable while valid&~ready.
  - A pop on valid&ready decrements outstanding by 1.
- Counter:
  - outstanding has width $clog2(RSQ_DEPTH+1).
  - A read accept and a response pop in the same cycle leave it unchanged.
  - It never exceeds RSQ_DEPTH.
  - The FIFO cannot overflow, because credits cover pipeline plus FIFO occupancy.
- FIFO:
  - Circular buffer of RSQ_DEPTH entries; pointers wrap modulo RSQ_DEPTH.
  - Push and pop in the same cycle when non-empty are both performed.
  - Push into an empty FIFO is visible next cycle (no bypass).
- Reset mid-operation: in-flight reads and queued responses are discarded, and no response is emitted for them after reset.

Decomposition:
- Package e_gpu_mem_pkg:
  - mem_rsp_entry_t struct holding data and tag.
  - Localparams for the data width (LINE_SIZE*8) and the SRAM index width.
- Sub-module mem_rsp_fifo: parameterized depth/width synchronous FIFO with push, pop, empty, full and head outputs.
- SRAM, latency pipeline and credit counter live in l2_mem_responder.

Test Plan:
1. Reset: rst_i=1 for 3 cycles -> ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0; first cycle after release ready=1.
2. Write/read: write addr 0x10, data 0xA5 repeated, byteen all-ones; next cycle read addr 0x10, tag 0x05 -> rsp_valid exactly 4 cycles after read accept, data all 0xA5, tag 0x05.
3. Partial write: fill addr 0x20 with 0xFF, then write 0x00 with byteen=0x000000000000000F, then read -> bytes 0-3 are 0x00, bytes 4-63 are 0xFF.
4. Backpressure: rsp_ready=0, offer 6 reads with tags 0-5 -> only tags 0-3 accepted, ready=0 after the 4th; raise rsp_ready -> tags 0,1,2,3 returned in order, data stable while stalled; ready returns the cycle after the first pop.
5. Simultaneous events: at outstanding=4, pop a response and accept a read in the same cycle -> outstanding stays 4; no response lost or duplicated.
6. Alias and reset: write addr 0x0405 (MEM_LINES=1024), read addr 0x005 -> same data; assert reset with 3 reads in flight -> no rsp_valid afterwards, and re-reading addr 0x005 returns the retained data.

Source files
------------

// File: rtl/e_gpu_mem_pkg.sv
// Shared types and widths for the L2 memory responder slice.
package e_gpu_mem_pkg;

  localparam int MEM_LINE_SIZE = 64;
  localparam int MEM_DATA_W    = MEM_LINE_SIZE * 8;
  localparam int MEM_TAG_W     = 8;
  localparam int MEM_DEPTH     = 1024;
  localparam int MEM_IDX_W     = $clog2(MEM_DEPTH);

  // One queued read response: the full line plus the tag of the read.
  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
    logic [MEM_TAG_W-1:0]  tag;
  } mem_rsp_entry_t;

  localparam int MEM_ENTRY_W = $bits(mem_rsp_entry_t);

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous circular-buffer FIFO holding read responses.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// A push into an empty FIFO becomes visible at head on the next cycle.
module mem_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO may still accept a push when it is popped the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = storage[rd_ptr];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L1 data cache miss port: a line-organised
// SRAM with fixed read latency and a credit-guarded response queue.
//
// Handshakes: a request transfers on a cycle where mem_req_valid_i and
// mem_req_ready_o are both 1; a response transfers on a cycle where
// mem_rsp_valid_o and mem_rsp_ready_i are both 1. Ready never depends on
// the same-side valid, and a valid response holds data/tag until taken.
module l2_mem_responder
  import e_gpu_mem_pkg::*;
#(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 4,
  parameter int RSQ_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_req_valid_i,
  input  logic                   mem_req_rw_i,
  input  logic [LINE_SIZE-1:0]   mem_req_byteen_i,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr_i,
  input  logic [LINE_SIZE*8-1:0] mem_req_data_i,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag_i,
  output logic                   mem_req_ready_o,
  output logic                   mem_rsp_valid_o,
  output logic [LINE_SIZE*8-1:0] mem_rsp_data_o,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag_o,
  input  logic                   mem_rsp_ready_i
);

  localparam int DATA_W = LINE_SIZE * 8;
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int CNT_W  = $clog2(RSQ_DEPTH + 1);
  // The SRAM read itself takes the accept cycle; the rest is register stages.
  localparam int STAGES = LATENCY - 1;

  logic [DATA_W-1:0] sram [MEM_LINES];
  logic [IDX_W-1:0]  idx;
  logic              req_fire;
  logic              wr_fire;
  logic              rd_fire;
  logic              rsp_fire;
  logic [CNT_W-1:0]  outstanding;
  mem_rsp_entry_t    rd_entry;
  mem_rsp_entry_t    push_entry;
  logic              push_valid;
  logic              fifo_empty;
  logic              fifo_full_unused;
  mem_rsp_entry_t    fifo_head;
  logic              addr_hi_unused;

  // Upper line-address bits alias onto the same SRAM line.
  assign idx            = mem_req_addr_i[IDX_W-1:0];
  assign addr_hi_unused = ^mem_req_addr_i[ADDR_WIDTH-1:IDX_W];

  // Credits cover every read from accept until its response is popped, so
  // the response FIFO can never overflow.
  assign mem_req_ready_o = ~rst_i & (outstanding < CNT_W'(RSQ_DEPTH));
  assign req_fire        = mem_req_valid_i & mem_req_ready_o;
  assign wr_fire         = req_fire & mem_req_rw_i;
  assign rd_fire         = req_fire & ~mem_req_rw_i;
  assign rsp_fire        = mem_rsp_valid_o & mem_rsp_ready_i;

  // Byte-masked line write; SRAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (mem_req_byteen_i[b]) begin
          sram[idx][8*b +: 8] <= mem_req_data_i[8*b +: 8];
        end
      end
    end
  end

  // Read the addressed line in the accept cycle and pair it with the tag.
  always_comb begin
    rd_entry      = '0;
    rd_entry.data = sram[idx];
    rd_entry.tag  = mem_req_tag_i;
  end

  generate
    if (STAGES == 0) begin : g_no_pipe
      assign push_valid = rd_fire;
      assign push_entry = rd_entry;
    end else begin : g_pipe
      logic [STAGES-1:0] pipe_valid;
      mem_rsp_entry_t    pipe_entry [STAGES];

      // Valid bits of the latency pipeline; reset drops in-flight reads.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= rd_fire;
          for (int s = 1; s < STAGES; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
          end
        end
      end

      // Payload of the latency pipeline, qualified by pipe_valid.
      always_ff @(posedge clk_i) begin
        pipe_entry[0] <= rd_entry;
        for (int s = 1; s < STAGES; s++) begin
          pipe_entry[s] <= pipe_entry[s-1];
        end
      end

      assign push_valid = pipe_valid[STAGES-1];
      assign push_entry = pipe_entry[STAGES-1];
    end
  endgenerate

  // Outstanding-read credit counter; accept and pop together cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  mem_rsp_fifo #(
    .DEPTH (RSQ_DEPTH),
    .WIDTH (MEM_ENTRY_W)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push_valid),
    .push_data (push_entry),
    .pop       (rsp_fire),
    .empty     (fifo_empty),
    .full      (fifo_full_unused),
    .head      (fifo_head)
  );

  // Outputs read as zero whenever no response is queued.
  assign mem_rsp_valid_o = ~fifo_empty;
  assign mem_rsp_data_o  = fifo_empty ? '0 : fifo_head.data;
  assign mem_rsp_tag_o   = fifo_empty ? '0 : fifo_head.tag;

endmodule
